logic_reduce_unit: RTL and testbench

Sequential multi-operand bitwise reducer placed in front of the CPU's combinational logic primitives. It accepts up to NB_INS operand buses, one per cycle, over a valid/ready handshake, and folds each one into an accumulator with a selected AND/OR/XOR/NAND operation. The registered result is then presented over a second valid/ready handshake to the downstream consumer. It lets wide N-input reductions run over a single narrow operand bus.

---
 rtl/logic_reduce_unit_pkg.sv | 17 +
 rtl/logic_reduce_unit_if.sv | 30 +++
 rtl/logic_reduce_unit_logic_op_step.sv | 24 ++
 rtl/logic_reduce_unit.sv | 95 +++++++++
 tb/tb_logic_reduce_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_reduce_unit_pkg.sv
// Shared encodings for the logic reduce unit: fold operations and FSM states.
package logic_reduce_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND  = 2'b00,
    OP_OR   = 2'b01,
    OP_XOR  = 2'b10,
    OP_NAND = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

endpackage

// File: rtl/logic_reduce_unit_if.sv
// Operand and result channels of the logic reduce unit.
// Both channels: a beat transfers on a rising clk edge where valid && ready; valid never depends on ready.
interface logic_reduce_if #(
  parameter int BUS_WIDTH = 8,
  parameter int NB_INS    = 4
);
  localparam int CNT_W = $clog2(NB_INS + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in_data;
  logic                 in_last;
  logic [1:0]           in_op;

  logic                 out_valid;
  logic                 out_ready;
  logic [BUS_WIDTH-1:0] out_data;
  logic [CNT_W-1:0]     out_count;
  logic                 out_trunc;

  modport master (
    output in_valid, in_data, in_last, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_trunc
  );

  modport slave (
    input  in_valid, in_data, in_last, in_op, out_ready,
    output in_ready, out_valid, out_data, out_count, out_trunc
  );
endinterface

// File: rtl/logic_reduce_unit_logic_op_step.sv
// One fold step of the reduction; NAND folds as AND and is inverted only at the output.
module logic_op_step
  import logic_reduce_unit_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] data_i,
  input  op_e          op_i,
  output logic [W-1:0] next_o
);

  always_comb begin
    next_o = acc_i & data_i;
    unique case (op_i)
      OP_AND,
      OP_NAND: next_o = acc_i & data_i;
      OP_OR:   next_o = acc_i | data_i;
      OP_XOR:  next_o = acc_i ^ data_i;
      default: next_o = acc_i & data_i;
    endcase
  end

endmodule

// File: rtl/logic_reduce_unit.sv
// Sequential multi-operand bitwise reducer: folds up to NB_INS operand beats into one registered result.
module logic_reduce_unit
  import logic_reduce_unit_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int NB_INS    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_reduce_if.slave        bus,
  output state_e               state_o
);

  localparam int CNT_W = $clog2(NB_INS + 1);
  localparam logic [CNT_W-1:0] NB_CNT = CNT_W'(NB_INS);

  state_e               state_q, state_d;
  logic [BUS_WIDTH-1:0] acc_q, acc_d;
  op_e                  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 trunc_q, trunc_d;

  logic [BUS_WIDTH-1:0] step_acc;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 beat_fire;

  logic_op_step #(.W(BUS_WIDTH)) u_step (
    .acc_i  (acc_q),
    .data_i (bus.in_data),
    .op_i   (op_q),
    .next_o (step_acc)
  );

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign beat_fire = bus.in_valid && (state_q != ST_DONE);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    trunc_d = trunc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (beat_fire) begin
          acc_d   = bus.in_data;
          op_d    = op_e'(bus.in_op);
          cnt_d   = CNT_W'(1);
          trunc_d = 1'b0;
          state_d = bus.in_last ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (beat_fire) begin
          acc_d   = step_acc;
          cnt_d   = cnt_inc;
          trunc_d = (cnt_inc == NB_CNT) && !bus.in_last;
          if (bus.in_last || (cnt_inc == NB_CNT)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          trunc_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      op_q    <= OP_AND;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  // Gating with rst_n keeps in_ready low for the whole reset window, not just the flops.
  assign bus.in_ready  = rst_n && (state_q != ST_DONE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = (op_q == OP_NAND) ? ~acc_q : acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_trunc = trunc_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Self-checking bench for logic_reduce_unit: directed scenarios plus randomized transactions vs a queue model.
module tb_logic_reduce_unit;
  import logic_reduce_unit_pkg::*;

  localparam int BW = 8;
  localparam int NB = 4;
  localparam int EW = 1 + 4 + BW;  // {trunc, count, data}

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_e dbg_state;
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     rand_rdy = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic [BW-1:0] cur_q[$];
  logic [1:0]    cur_op;

  logic_reduce_if #(.BUS_WIDTH(BW), .NB_INS(NB)) bus ();

  logic_reduce_unit #(.BUS_WIDTH(BW), .NB_INS(NB)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: fold the beats in order, invert for NAND, pack with count and truncation flag.
  function automatic logic [EW-1:0] model_result(input logic [1:0] op, input logic [BW-1:0] b[$],
                                                 input bit trunc);
    logic [BW-1:0] r;
    r = b[0];
    for (int i = 1; i < b.size(); i++) begin
      if (op == 2'd1)      r = r | b[i];
      else if (op == 2'd2) r = r ^ b[i];
      else                 r = r & b[i];
    end
    if (op == 2'd3) r = ~r;
    return {trunc, 4'(b.size()), r};
  endfunction

  // model: tracks transfers at each rising edge from the rules of the protocol
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cur_q.delete();
        exp_q.delete();
      end else if (exp_q.size() != 0) begin
        if (bus.out_ready) void'(exp_q.pop_front());
      end else if (bus.in_valid) begin
        if (cur_q.size() == 0) cur_op = bus.in_op;
        cur_q.push_back(bus.in_data);
        if (bus.in_last || cur_q.size() == NB) begin
          exp_q.push_back(model_result(cur_op, cur_q, !bus.in_last));
          cur_q.delete();
        end
      end
    end
  end

  // compare: every falling edge, outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_count", bus.out_count, 0);
        chk("rst_out_trunc", bus.out_trunc, 0);
      end else begin
        chk("in_ready", bus.in_ready, exp_q.size() == 0);
        chk("out_valid", bus.out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          chk("out_data", bus.out_data, exp_q[0][BW-1:0]);
          chk("out_count", bus.out_count, exp_q[0][BW+3:BW]);
          chk("out_trunc", bus.out_trunc, exp_q[0][EW-1]);
        end
      end
    end
  end

  // driver: called at a falling edge, returns at the falling edge after the beat transferred
  task automatic send_beat(input logic [BW-1:0] d, input logic last, input logic [1:0] op);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_op    = op;
    for (int i = 0; i < 60; i++) begin
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      if (ok) break;
      @(negedge clk);
    end
    chk("beat_accept_timeout", ok, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
  endtask

  task automatic expect_result(input string name, input logic [BW-1:0] d, input int cnt, input logic tr);
    bit got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.out_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_seen"}, got, 1);
    chk({name, "_data"}, bus.out_data, d);
    chk({name, "_count"}, bus.out_count, cnt);
    chk({name, "_trunc"}, bus.out_trunc, tr);
  endtask

  initial begin
    logic [BW-1:0] pin_q[$];
    logic [1:0]    op;
    int            len;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_op     = 2'd0;
    bus.out_ready = 1'b1;

    pin_q = '{8'hF0, 8'h3C, 8'hFF};
    chk("model_pin_and", model_result(2'd0, pin_q, 1'b0), {1'b0, 4'd3, 8'h30});
    pin_q = '{8'hAA, 8'h55, 8'h0F, 8'h01};
    chk("model_pin_xor", model_result(2'd2, pin_q, 1'b1), {1'b1, 4'd4, 8'hF1});

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // AND of three beats, result right after the last beat
    send_beat(8'hF0, 1'b0, 2'd0);
    send_beat(8'h3C, 1'b0, 2'd2);
    send_beat(8'hFF, 1'b1, 2'd1);
    chk("and_latency", bus.out_valid, 1);
    expect_result("and3", 8'h30, 3, 1'b0);
    @(negedge clk);

    // XOR cut at NB beats; next beat held off while the result waits
    bus.out_ready = 1'b0;
    send_beat(8'hAA, 1'b0, 2'd2);
    send_beat(8'h55, 1'b0, 2'd0);
    send_beat(8'h0F, 1'b0, 2'd0);
    send_beat(8'h01, 1'b0, 2'd0);
    expect_result("xor_trunc", 8'hF1, 4, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    bus.in_last  = 1'b1;
    bus.in_op    = 2'd1;
    @(negedge clk);
    chk("held_off_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    send_beat(8'h77, 1'b1, 2'd1);
    expect_result("after_trunc", 8'h77, 1, 1'b0);
    @(negedge clk);

    // NAND single beat with a stalled consumer
    bus.out_ready = 1'b0;
    send_beat(8'h0F, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      chk("nand_hold_valid", bus.out_valid, 1);
      chk("nand_hold_data", bus.out_data, 8'hF0);
      chk("nand_hold_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("nand_back_idle", bus.in_ready, 1);

    // OR with an input gap; op on the later beat is ignored
    send_beat(8'h01, 1'b0, 2'd1);
    idle_cycles(2);
    send_beat(8'h80, 1'b1, 2'd0);
    expect_result("or_gap", 8'h81, 2, 1'b0);
    @(negedge clk);

    // reset mid-transaction, then a fresh transaction
    send_beat(8'hF0, 1'b0, 2'd0);
    send_beat(8'h3C, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_count", bus.out_count, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send_beat(8'h11, 1'b0, 2'd1);
    send_beat(8'h22, 1'b1, 2'd1);
    expect_result("or_after_rst", 8'h33, 2, 1'b0);

    // back-to-back transactions
    send_beat(8'hAA, 1'b1, 2'd2);
    expect_result("b2b_first", 8'hAA, 1, 1'b0);
    send_beat(8'h0F, 1'b0, 2'd1);
    send_beat(8'hF0, 1'b1, 2'd3);
    expect_result("b2b_second", 8'hFF, 2, 1'b0);
    @(negedge clk);

    // randomized traffic
    rand_rdy = 1'b1;
    for (int t = 0; t < 300; t++) begin
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        send_beat(8'($urandom_range(0, 255)), (j == len - 1) && (len < 5),
                  (j == 0) ? op : 2'($urandom_range(0, 3)));
        idle_cycles($urandom_range(0, 2));
      end
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    send_beat(8'h5A, 1'b1, 2'd0);
    idle_cycles(6);
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
